alarm_ringer: RTL and testbench

ALARM_RINGER -- requirements
Module: alarm_ringer

---
 rtl/clock_pkg.sv | 7 +
 rtl/ms_tick_gen.sv | 16 +
 rtl/alarm_ringer.sv | 95 +++++++++
 tb/tb_alarm_ringer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared alarm FSM state encodings and the 1 ms divide helper
package clock_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;
  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running 1 ms tick divider, restartable by clr
module ms_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [31:0] cnt_q, cnt_d;
  assign tick = cnt_q == 32'(DIV - 1);
  // next count: restart on clear or wrap after the tick cycle
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 32'd1;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer: beeping alarm with timeout; snooze support under macro ALARM_SNOOZE_EN
module alarm_ringer
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TONE_HZ     = 2000,
  parameter int BEEP_ON_MS  = 500,
  parameter int BEEP_OFF_MS = 500,
  parameter int TIMEOUT_MS  = 60000,
  parameter int SNOOZE_MS   = 300000
) (
  input  logic clk,
  input  logic rst,
  input  logic ring,
  input  logic stop_btn,
  input  logic snooze_btn,
  output logic buzzer,
  output logic active,
  output logic snoozing
);
  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int PER  = BEEP_ON_MS + BEEP_OFF_MS;
  state_t state_q, state_d;
  logic ring_q, tick, entry, trigger, timeout, snooze_req, snooze_done;
  logic [31:0] elapsed_q, elapsed_d, period_q, period_d, tone_cnt_q, tone_cnt_d;
  logic tone_q, tone_d, buzzer_q, buzzer_d, active_q, active_d;
  assign trigger = ring & ~ring_q;
  assign entry   = state_d != state_q;
  assign timeout = tick && elapsed_q == 32'(TIMEOUT_MS - 1);
`ifdef ALARM_SNOOZE_EN
  logic snoozing_q, snoozing_d;
  assign snooze_req  = snooze_btn;
  assign snooze_done = tick && elapsed_q == 32'(SNOOZE_MS - 1);
  assign snoozing    = snoozing_q;
  // snooze indicator follows the state register
  always_comb snoozing_d = state_d == SNOOZE;
  // snooze indicator register
  always_ff @(posedge clk) snoozing_q <= rst ? 1'b0 : snoozing_d;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_btn ^ (SNOOZE_MS == 0);
  assign snooze_req    = 1'b0;
  assign snooze_done   = 1'b0;
  assign snoozing      = 1'b0;
`endif
  ms_tick_gen #(.DIV(ms_div(CLK_HZ))) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (entry),
    .tick(tick)
  );
  // next state: stop beats snooze beats timeout/expiry beats trigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = trigger ? RINGING : IDLE;
      RINGING: state_d = stop_btn ? IDLE : snooze_req ? SNOOZE : timeout ? IDLE : RINGING;
      SNOOZE:  state_d = stop_btn ? IDLE : (trigger || snooze_done) ? RINGING : SNOOZE;
      default: state_d = IDLE;
    endcase
  end
  // ms timers and tone generator, all restarted on every state entry
  always_comb begin
    elapsed_d  = entry ? '0 : elapsed_q + 32'(tick);
    period_d   = entry ? '0 : !tick ? period_q : period_q == 32'(PER - 1) ? '0 : period_q + 32'd1;
    tone_cnt_d = (entry || state_q != RINGING || tone_cnt_q == 32'(HALF - 1)) ? '0 : tone_cnt_q + 32'd1;
    tone_d     = (entry || state_q != RINGING) ? 1'b0 : tone_cnt_q == 32'(HALF - 1) ? ~tone_q : tone_q;
    buzzer_d   = tone_q && period_q < 32'(BEEP_ON_MS) && state_q == RINGING;
    active_d   = state_d == RINGING;
  end
  // state, history and output registers; ring history resets high so a held ring cannot trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ring_q     <= 1'b1;
      elapsed_q  <= '0;
      period_q   <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      buzzer_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_q     <= ring;
      elapsed_q  <= elapsed_d;
      period_q   <= period_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      buzzer_q   <= buzzer_d;
      active_q   <= active_d;
    end
  end
  assign buzzer = buzzer_q;
  assign active = active_q;
endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: directed self-checking bench for alarm_ringer (small clock parameters)
module tb_alarm_ringer;
  logic clk = 1'b0, rst = 1'b1, ring = 1'b0, stop_btn = 1'b0, snooze_btn = 1'b0;
  logic buzzer, active, snoozing;
  int n_checks = 0, n_fail = 0;

  alarm_ringer #(
    .CLK_HZ(10000), .TONE_HZ(1000), .BEEP_ON_MS(5), .BEEP_OFF_MS(5),
    .TIMEOUT_MS(40), .SNOOZE_MS(20)
  ) dut (
    .clk(clk), .rst(rst), .ring(ring), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .buzzer(buzzer), .active(active), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // buzzer expected at edge k after entering RINGING (k>=1): tone half-period 5, beep period 10 ms of 10 clk
  function automatic logic beep(input int k);
    int m;
    m = k - 1;
    return ((m / 5) % 2 == 1) && ((m / 10) % 10 < 5);
  endfunction

  // raise ring so that the following edge is the trigger edge
  task automatic fire();
    ring = 1'b0;
    step();
    ring = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ring = 1'b1;
    step(3);
    n_checks++;
    if ({active, buzzer, snoozing} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 000", {active, buzzer, snoozing});
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (active !== 1'b0) begin
        n_fail++;
        $display("FAIL ring_held_through_reset k=%0d active got %b exp 0", k, active);
      end
    end
    ring = 1'b0;
    step();
  endtask

  task automatic test_ring_timeout();
    fire();
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_active_first got %b exp 1", active);
    end
    for (int k = 1; k <= 420; k++) begin
      if (k == 30) ring = 1'b0;
      step();
      n_checks++;
      if (active !== (k < 400)) begin
        n_fail++;
        $display("FAIL timeout_active k=%0d got %b exp %b", k, active, k < 400);
      end
      n_checks++;
      if (buzzer !== (k <= 400 && beep(k))) begin
        n_fail++;
        $display("FAIL beep_pattern k=%0d got %b exp %b", k, buzzer, k <= 400 && beep(k));
      end
      n_checks++;
      if (snoozing !== 1'b0) begin
        n_fail++;
        $display("FAIL ring_snoozing k=%0d got %b exp 0", k, snoozing);
      end
    end
  endtask

  task automatic test_stop_and_snooze_together();
    fire();
    step(19);
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    n_checks++;
    if ({active, snoozing} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_snooze_same_cycle got %b exp 00", {active, snoozing});
    end
    step(3);
    n_checks++;
    if ({active, snoozing, buzzer} !== 3'b000) begin
      n_fail++;
      $display("FAIL stop_settled got %b exp 000", {active, snoozing, buzzer});
    end
    ring = 1'b0;
    step();
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    fire();
    ring = 1'b0;
    step(119);
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    for (int k = 1; k <= 230; k++) begin
      n_checks++;
      if ({active, snoozing} !== ((k <= 200) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL snooze_state k=%0d got %b exp %b", k, {active, snoozing}, (k <= 200) ? 2'b01 : 2'b10);
      end
      if (k >= 2) begin
        n_checks++;
        if (buzzer !== (k > 200 && beep(k - 200))) begin
          n_fail++;
          $display("FAIL snooze_beep k=%0d got %b exp %b", k, buzzer, k > 200 && beep(k - 200));
        end
      end
      step();
    end
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze_cleanup active got %b exp 0", active);
    end
  endtask
`else
  task automatic test_snooze();
    fire();
    ring = 1'b0;
    step(119);
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    for (int k = 120; k <= 410; k++) begin
      n_checks++;
      if ({active, snoozing} !== ((k < 400) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL snooze_ignored k=%0d got %b exp %b", k, {active, snoozing}, (k < 400) ? 2'b10 : 2'b00);
      end
      step();
    end
  endtask
`endif

  task automatic test_reset_mid_ring();
    fire();
    step(30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({active, buzzer, snoozing} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_ring got %b exp 000", {active, buzzer, snoozing});
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (active !== 1'b0) begin
        n_fail++;
        $display("FAIL no_retrigger k=%0d got %b exp 0", k, active);
      end
    end
    fire();
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL retrigger_after_fall got %b exp 1", active);
    end
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    ring = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_stop_and_snooze_together();
    test_snooze();
    test_reset_mid_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
